stream_dmux_rr: RTL and testbench

- Registered 1-to-NUM_CH stream demultiplexer for the systolic BN datapath. Distributes 16-bit operands from one producer to NUM_CH consumer columns (PE rows, mean/var accumulators).
- Uses a valid/ready handshake, so back-pressure works per channel.
- Two routing modes: explicit select (sel port), or automatic round-robin with a programmable burst length per channel.
- Each output has a one-entry holding register. A stalled column blocks only beats routed to that column.

---
 rtl/bn_stream_pkg.sv | 15 +
 rtl/stream_dmux_rr_if.sv | 32 +++
 rtl/stream_slot.sv | 37 +++
 rtl/stream_dmux_rr.sv | 95 +++++++++
 tb/tb_stream_dmux_rr.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/bn_stream_pkg.sv
// Shared definitions for the BN stream datapath: default widths, routing mode
// encodings and the select-width helper.
package bn_stream_pkg;

  localparam int DATA_WIDTH_DEF = 16;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  // Width of a channel index; never narrower than one bit.
  function automatic int ch_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_dmux_rr_if.sv
// Producer/consumer bundle of the round-robin stream demultiplexer.
interface stream_dmux_rr_if
  import bn_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_CH     = 3
);

  localparam int CH_W = ch_w(NUM_CH);

  logic                         mode;
  logic [CH_W-1:0]              sel;
  logic                         in_valid;
  logic                         in_ready;
  logic [DATA_WIDTH-1:0]        in_data;
  logic [NUM_CH-1:0]            out_valid;
  logic [NUM_CH-1:0]            out_ready;
  logic [NUM_CH*DATA_WIDTH-1:0] out_data;
  logic [CH_W-1:0]              cur_chan;
  logic                         drop;

  modport slave (
    input  mode, sel, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, cur_chan, drop
  );

  modport master (
    output mode, sel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, cur_chan, drop
  );

endinterface

// File: rtl/stream_slot.sv
// One-entry output holding register with load, drain and same-edge refill.
module stream_slot
  import bn_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  ready_in,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] dout
);

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;

  // Load wins over drain so a refill on the draining edge leaves no bubble;
  // a plain drain zeroes the payload so idle lanes always read as 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (load) begin
      r_valid <= 1'b1;
      r_data  <= din;
    end else if (r_valid && ready_in) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end
  end

  assign valid_out = r_valid;
  assign dout      = r_data;

endmodule

// File: rtl/stream_dmux_rr.sv
// Registered 1-to-NUM_CH stream demultiplexer with explicit-select and
// burst round-robin routing; each channel stalls independently.
module stream_dmux_rr
  import bn_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_CH     = 3,
  parameter int BURST      = 4
) (
  input  logic             clk,
  input  logic             rst,
  stream_dmux_rr_if.slave  bus
);

  localparam int CH_W  = ch_w(NUM_CH);
  localparam int CNT_W = ch_w(BURST);

  logic [CH_W-1:0]                   r_ptr;
  logic [CNT_W-1:0]                  r_cnt;
  logic                              r_drop;

  logic [CH_W-1:0]                   w_tgt;
  logic [NUM_CH-1:0]                 w_hit;
  logic [NUM_CH-1:0]                 w_valid;
  logic [NUM_CH-1:0]                 w_slot_rdy;
  logic [NUM_CH-1:0]                 w_load;
  logic                              w_in_range;
  logic                              w_in_ready;
  logic                              w_accept;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] w_dout;

  assign w_tgt = (bus.mode == MODE_RR) ? r_ptr : bus.sel;

  // One-hot decode of the target; an out-of-range select leaves it all-zero.
  always_comb begin
    w_hit = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_hit[k] = (w_tgt == CH_W'(k));
    end
  end

  assign w_in_range = |w_hit;
  assign w_slot_rdy = ~w_valid | bus.out_ready;
  assign w_in_ready = w_in_range ? |(w_hit & w_slot_rdy) : 1'b1;
  assign w_accept   = bus.in_valid & w_in_ready;
  assign w_load     = {NUM_CH{w_accept}} & w_hit;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
    stream_slot #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (w_load[g]),
      .din       (bus.in_data),
      .ready_in  (bus.out_ready[g]),
      .valid_out (w_valid[g]),
      .dout      (w_dout[g])
    );
  end

  // Pointer only moves on accepted beats, so a stalled column holds it;
  // select mode parks it at channel 0 with a fresh burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (bus.mode == MODE_SEL) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      if (r_cnt == CNT_W'(BURST - 1)) begin
        r_cnt <= '0;
        r_ptr <= (r_ptr == CH_W'(NUM_CH - 1)) ? '0 : r_ptr + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop <= 1'b0;
    end else begin
      r_drop <= w_accept & ~w_in_range;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_valid;
  assign bus.out_data  = w_dout;
  assign bus.cur_chan  = w_tgt;
  assign bus.drop      = r_drop;

endmodule

// File: tb/tb_stream_dmux_rr.sv
// Randomized scoreboard bench for stream_dmux_rr against a queue-based model.
module tb_stream_dmux_rr;
  import bn_stream_pkg::*;

  localparam int DW   = 16;
  localparam int NCH  = 3;
  localparam int BUR  = 4;
  localparam int CH_W = ch_w(NCH);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stream_dmux_rr_if #(.DATA_WIDTH(DW), .NUM_CH(NCH)) bus ();

  stream_dmux_rr #(
    .DATA_WIDTH (DW),
    .NUM_CH     (NCH),
    .BURST      (BUR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] expq [NCH][$];
  bit            occ  [NCH];
  int            deliv[NCH];
  int            auto_beats;
  bit            exp_drop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: every handshaken output beat must match the oldest expected beat.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < NCH; k++) begin
        if (bus.out_valid[k] && bus.out_ready[k]) begin
          deliv[k]++;
          if (expq[k].size() == 0) begin
            n_checks++;
            $display("FAIL ch%0d_unexpected: got beat %0h, expected none", k,
                     bus.out_data[k*DW +: DW]);
          end else begin
            chk($sformatf("ch%0d_data", k), 32'(bus.out_data[k*DW +: DW]), 32'(expq[k].pop_front()));
          end
        end else if (!bus.out_valid[k]) begin
          chk($sformatf("ch%0d_idle_zero", k), 32'(bus.out_data[k*DW +: DW]), 32'd0);
        end
      end
    end
  end

  // One clock of stimulus: drive, check the model's view of the current cycle,
  // then advance the model across the coming edge.
  task automatic cycle(input bit m, input logic [CH_W-1:0] s, input bit v,
                       input logic [DW-1:0] d, input logic [NCH-1:0] r);
    int tgt;
    bit er, acc;
    @(posedge clk);
    #1;
    bus.mode = m; bus.sel = s; bus.in_valid = v; bus.in_data = d; bus.out_ready = r;
    @(negedge clk);
    #1;
    for (int k = 0; k < NCH; k++) chk($sformatf("out_valid%0d", k), 32'(bus.out_valid[k]), 32'(occ[k]));
    chk("drop", 32'(bus.drop), 32'(exp_drop));
    tgt = m ? (auto_beats / BUR) % NCH : int'(s);
    er  = (tgt >= NCH) ? 1'b1 : (!occ[tgt] || r[tgt]);
    chk("in_ready", 32'(bus.in_ready), 32'(er));
    chk("cur_chan", 32'(bus.cur_chan), 32'(tgt));
    acc = v && er;
    for (int k = 0; k < NCH; k++) if (occ[k] && r[k]) occ[k] = 1'b0;
    exp_drop = acc && (tgt >= NCH);
    if (acc && tgt < NCH) begin
      occ[tgt] = 1'b1;
      expq[tgt].push_back(d);
    end
    if (!m) auto_beats = 0;
    else if (acc) auto_beats++;
  endtask

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin
      expq[k].delete();
      occ[k] = 1'b0;
    end
    auto_beats = 0;
    exp_drop   = 1'b0;
  endtask

  initial begin
    int d0;
    bit rm;
    bus.mode = 1'b0; bus.sel = '0; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = '0;
    for (int k = 0; k < NCH; k++) deliv[k] = 0;
    model_reset();
    rst = 1'b1;
    #2;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data",  32'(bus.out_data), 32'd0);
    chk("rst_drop",      32'(bus.drop), 32'd0);
    chk("rst_cur_chan",  32'(bus.cur_chan), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Select-mode load with every consumer stalled.
    cycle(0, 2'd1, 1, 16'hA5A5, 3'b000);
    cycle(0, 2'd1, 0, 16'h0000, 3'b000);
    chk("t1_valid", 32'(bus.out_valid), 32'b010);
    chk("t1_slice1", 32'(bus.out_data[DW +: DW]), 32'hA5A5);
    cycle(0, 2'd0, 0, 16'h0000, 3'b000);

    // Pass-through refill: eight beats delivered in eight cycles.
    d0 = deliv[1];
    for (int i = 0; i < 8; i++) cycle(0, 2'd1, 1, 16'(i + 1), 3'b010);
    chk("t2_throughput", 32'(deliv[1] - d0), 32'd8);

    // Out-of-range select is swallowed and flagged for exactly one cycle.
    cycle(0, 2'd3, 1, 16'hDEAD, 3'b000);
    cycle(0, 2'd0, 0, 16'h0000, 3'b000);
    chk("t3_drop", 32'(bus.drop), 32'd1);
    cycle(0, 2'd0, 0, 16'h0000, 3'b010);

    // Auto mode bursts of four across all channels.
    for (int i = 0; i < 12; i++) cycle(1, 2'd0, 1, 16'(i), 3'b111);
    cycle(1, 2'd0, 0, 16'h0000, 3'b111);
    chk("t4_wrap", 32'(bus.cur_chan), 32'd0);

    // Channel 1 stalls mid-burst; the pointer must hold.
    for (int i = 0; i < 12; i++) begin
      cycle(1, 2'd0, 1, 16'(16'h100 + i), (i >= 4 && i < 7) ? 3'b101 : 3'b111);
      if (i == 6) chk("t5_hold", 32'(bus.cur_chan), 32'd1);
    end
    for (int i = 0; i < 3; i++) cycle(1, 2'd0, 0, 16'h0000, 3'b111);

    // Asynchronous reset mid-cycle with full slots.
    cycle(1, 2'd0, 1, 16'h0055, 3'b000);
    cycle(1, 2'd0, 1, 16'h0056, 3'b000);
    @(posedge clk);
    #3;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("t6_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_data",  32'(bus.out_data), 32'd0);
    chk("t6_chan",  32'(bus.cur_chan), 32'd0);
    model_reset();
    @(posedge clk); #1 rst = 1'b0;
    cycle(1, 2'd0, 1, 16'h0077, 3'b000);
    cycle(1, 2'd0, 0, 16'h0000, 3'b000);
    chk("t6_first_ch0", 32'(bus.out_data[0 +: DW]), 32'h0077);
    cycle(1, 2'd0, 0, 16'h0000, 3'b111);

    // Randomized traffic with occasional mode flips.
    rm = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(15, 0) == 0) rm = ~rm;
      cycle(rm, CH_W'($urandom_range(3, 0)), 1'($urandom_range(1, 0)),
            16'($urandom), NCH'($urandom_range(7, 0)));
    end
    for (int i = 0; i < 4; i++) cycle(rm, 2'd0, 0, 16'h0000, 3'b111);
    for (int k = 0; k < NCH; k++) chk($sformatf("ch%0d_queue_empty", k), 32'(expq[k].size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
